// File: rtl/microwave_timer_ctrl_if.sv
// Signal bundle between the microwave timer controller and its keypad/door/counter-chain surroundings.
// The slave side is the controller; the master side drives keypad, door and chain-status inputs.
interface microwave_timer_ctrl_if;
    logic       digits_valid;
    logic       start;
    logic       stop;
    logic       door_closed;
    logic       cnt_zero;
    logic       cnt_loadn;
    logic       cnt_clrn;
    logic       cnt_en;
    logic       mag_on;
    logic       light_on;
    logic       beep;
    logic [2:0] state;

    modport master (
        output digits_valid, start, stop, door_closed, cnt_zero,
        input  cnt_loadn, cnt_clrn, cnt_en, mag_on, light_on, beep, state
    );

    modport slave (
        input  digits_valid, start, stop, door_closed, cnt_zero,
        output cnt_loadn, cnt_clrn, cnt_en, mag_on, light_on, beep, state
    );
endinterface

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-timer sequencer: loads/clears the mm:ss counter chain, makes the one-second count enable
// and drives magnetron, light and beeper. Define MWTC_PAUSE_TIMEOUT_EN to auto-cancel an over-long pause.
module microwave_timer_ctrl #(
    parameter int TICK_DIV      = 100,
    parameter int BEEP_TICKS    = 3,
    parameter int PAUSE_TIMEOUT = 600
) (
    input  logic                  clk,
    input  logic                  clr,
    microwave_timer_ctrl_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOADED = 3'd1,
        S_COOK   = 3'd2,
        S_PAUSE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] beep_cnt_q, beep_cnt_d;
    logic          cnt_loadn_q, cnt_loadn_d;
    logic          cnt_clrn_q, cnt_clrn_d;
    logic          cnt_en_q, cnt_en_d;
    logic          mag_on_q, mag_on_d;
    logic          light_on_q, light_on_d;
    logic          beep_q, beep_d;
    logic          tick;

`ifdef MWTC_PAUSE_TIMEOUT_EN
    localparam int PCW = $clog2(PAUSE_TIMEOUT + 1);
    localparam logic [PCW-1:0] PAUSE_LIMIT = PCW'(PAUSE_TIMEOUT);
    logic [PCW-1:0] pause_cnt_q, pause_cnt_d, pause_cnt_inc;
    assign pause_cnt_inc = pause_cnt_q + PCW'(1);
`else
    logic unused_pause_cfg;
    assign unused_pause_cfg = (PAUSE_TIMEOUT > 0);
`endif

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        beep_cnt_d  = beep_cnt_q;
        cnt_loadn_d = 1'b1;
        cnt_clrn_d  = 1'b1;
        cnt_en_d    = 1'b0;
`ifdef MWTC_PAUSE_TIMEOUT_EN
        pause_cnt_d = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.digits_valid && !bus.stop) begin
                    state_d     = S_LOADED;
                    cnt_loadn_d = 1'b0;
                end
            end
            S_LOADED: begin
                if (bus.stop) begin
                    state_d    = S_IDLE;
                    cnt_clrn_d = 1'b0;
                end else if (bus.digits_valid) begin
                    cnt_loadn_d = 1'b0;
                end else if (bus.start && bus.door_closed && !bus.cnt_zero) begin
                    state_d = S_COOK;
                    presc_d = '0;
                end
            end
            S_COOK: begin
                // Zero check comes first so the chain never gets a decrement at 00:00.
                if (bus.cnt_zero) begin
                    state_d    = S_DONE;
                    presc_d    = '0;
                    beep_cnt_d = '0;
                end else if (!bus.door_closed || bus.stop) begin
                    state_d = S_PAUSE;
                end else begin
                    presc_d  = tick ? '0 : presc_q + PW'(1);
                    cnt_en_d = tick;
                end
            end
            S_PAUSE: begin
                if (bus.stop) begin
                    state_d    = S_IDLE;
                    cnt_clrn_d = 1'b0;
                end else if (bus.start && bus.door_closed) begin
                    state_d = S_COOK;
                end
`ifdef MWTC_PAUSE_TIMEOUT_EN
                else if (pause_cnt_inc == PAUSE_LIMIT) begin
                    state_d    = S_IDLE;
                    cnt_clrn_d = 1'b0;
                end else begin
                    pause_cnt_d = pause_cnt_inc;
                end
`endif
            end
            S_DONE: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        if (beep_cnt_q == BEEP_LAST) begin
                            state_d = S_IDLE;
                        end else begin
                            beep_cnt_d = beep_cnt_q + BW'(1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        mag_on_d   = (state_d == S_COOK);
        light_on_d = (state_d == S_COOK) || ((state_d == S_PAUSE) && !bus.door_closed);
        beep_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            beep_cnt_q  <= '0;
            cnt_loadn_q <= 1'b1;
            cnt_clrn_q  <= 1'b0;
            cnt_en_q    <= 1'b0;
            mag_on_q    <= 1'b0;
            light_on_q  <= 1'b0;
            beep_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            beep_cnt_q  <= beep_cnt_d;
            cnt_loadn_q <= cnt_loadn_d;
            cnt_clrn_q  <= cnt_clrn_d;
            cnt_en_q    <= cnt_en_d;
            mag_on_q    <= mag_on_d;
            light_on_q  <= light_on_d;
            beep_q      <= beep_d;
        end
    end

`ifdef MWTC_PAUSE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            pause_cnt_q <= '0;
        end else begin
            pause_cnt_q <= pause_cnt_d;
        end
    end
`endif

    assign bus.cnt_loadn = cnt_loadn_q;
    assign bus.cnt_clrn  = cnt_clrn_q;
    assign bus.cnt_en    = cnt_en_q;
    assign bus.mag_on    = mag_on_q;
    assign bus.light_on  = light_on_q;
    assign bus.beep      = beep_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: directed scenarios plus random keypad/door/start/stop traffic,
// compared every cycle against a seconds-level reference model and a behavioural counter chain.
module tb_microwave_timer_ctrl;
    localparam int TD = 4;
    localparam int BT = 2;
    localparam int PT = 6;

    localparam int M_IDLE   = 0;
    localparam int M_LOADED = 1;
    localparam int M_COOK   = 2;
    localparam int M_PAUSE  = 3;
    localparam int M_DONE   = 4;

    logic clk = 1'b0;
    logic clr = 1'b1;
    microwave_timer_ctrl_if bus();

    microwave_timer_ctrl #(
        .TICK_DIV     (TD),
        .BEEP_TICKS   (BT),
        .PAUSE_TIMEOUT(PT)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural counter chain: whole seconds remaining, wraps 0 -> 59 if decremented at zero.
    int key_secs = 0;
    int chain_secs = 0;
    always @(posedge clk) begin
        if (bus.cnt_loadn === 1'b0)      chain_secs <= key_secs;
        else if (bus.cnt_clrn === 1'b0)  chain_secs <= 0;
        else if (bus.cnt_en === 1'b1)    chain_secs <= (chain_secs == 0) ? 59 : chain_secs - 1;
    end
    assign bus.cnt_zero = (chain_secs == 0);

    // Reference model: mode, position within the current second, remaining beep cycles, cycles paused.
    int   m_mode = M_IDLE;
    int   m_phase = 0;
    int   m_done_left = 0;
    int   m_pause_cnt = 0;
    logic e_loadn = 1'b1, e_clrn = 1'b1, e_en = 1'b0;
    logic e_mag = 1'b0, e_light = 1'b0, e_beep = 1'b0;

    always @(posedge clk) begin
        e_loadn = 1'b1;
        e_clrn  = 1'b1;
        e_en    = 1'b0;
        if (clr) begin
            m_mode = M_IDLE; m_phase = 0; m_done_left = 0; m_pause_cnt = 0;
            e_clrn = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: if (bus.digits_valid && !bus.stop) begin m_mode = M_LOADED; e_loadn = 1'b0; end
                M_LOADED: begin
                    if (bus.stop) begin m_mode = M_IDLE; e_clrn = 1'b0; end
                    else if (bus.digits_valid) e_loadn = 1'b0;
                    else if (bus.start && bus.door_closed && !bus.cnt_zero) begin m_mode = M_COOK; m_phase = 0; end
                end
                M_COOK: begin
                    if (bus.cnt_zero) begin m_mode = M_DONE; m_done_left = BT * TD; end
                    else if (!bus.door_closed || bus.stop) begin m_mode = M_PAUSE; m_pause_cnt = 0; end
                    else begin
                        e_en = (m_phase == TD - 1);
                        m_phase = (m_phase + 1) % TD;
                    end
                end
                M_PAUSE: begin
                    if (bus.stop) begin m_mode = M_IDLE; e_clrn = 1'b0; end
                    else if (bus.start && bus.door_closed) m_mode = M_COOK;
`ifdef MWTC_PAUSE_TIMEOUT_EN
                    else begin
                        m_pause_cnt++;
                        if (m_pause_cnt == PT) begin m_mode = M_IDLE; e_clrn = 1'b0; end
                    end
`endif
                end
                M_DONE: begin
                    if (bus.stop) m_mode = M_IDLE;
                    else begin
                        m_done_left--;
                        if (m_done_left == 0) m_mode = M_IDLE;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
        e_mag   = (m_mode == M_COOK);
        e_light = (m_mode == M_COOK) || (m_mode == M_PAUSE && !bus.door_closed);
        e_beep  = (m_mode == M_DONE);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("cyc_state", 32'(bus.state), 32'(m_mode));
            check_eq("cyc_outs",
                     {26'd0, bus.mag_on, bus.light_on, bus.beep, bus.cnt_en, bus.cnt_loadn, bus.cnt_clrn},
                     {26'd0, e_mag, e_light, e_beep, e_en, e_loadn, e_clrn});
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_dv(input int secs);
        key_secs = secs;
        bus.digits_valid = 1'b1;
        cyc(1);
        bus.digits_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] en_mask;
        int beeps;
        logic en_seen;

        bus.digits_valid = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.door_closed = 1'b1;

        // Reset
        clr = 1'b1;
        cyc(1);
        chk_en = 1'b1;
        check_eq("rst_state", 32'(bus.state), 32'd0);
        check_eq("rst_outs", {27'd0, bus.mag_on, bus.light_on, bus.beep, bus.cnt_en, bus.cnt_loadn}, 32'h1);
        check_eq("rst_clrn", 32'(bus.cnt_clrn), 32'd0);
        clr = 1'b0;
        cyc(1);
        check_eq("rst_clrn_rel", 32'(bus.cnt_clrn), 32'd1);

        // Load 00:03 and cook to completion
        pulse_dv(3);
        check_eq("load_low", 32'(bus.cnt_loadn), 32'd0);
        check_eq("load_state", 32'(bus.state), 32'd1);
        cyc(1);
        check_eq("load_one_cyc", 32'(bus.cnt_loadn), 32'd1);
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        check_eq("cook_state", 32'(bus.state), 32'd2);
        check_eq("cook_mag", 32'(bus.mag_on), 32'd1);
        en_mask = '0;
        beeps = 0;
        for (int k = 1; k <= 30; k++) begin
            cyc(1);
            if (bus.cnt_en) en_mask[k] = 1'b1;
            if (bus.beep) beeps++;
        end
        check_eq("tick_cycles", en_mask, 32'h0000_1110);
        check_eq("beep_len", 32'(beeps), 32'd8);
        check_eq("done_idle", 32'(bus.state), 32'd0);

        // LOADED: start ignored with door open or at zero; start+stop cancels
        pulse_dv(5);
        cyc(1);
        bus.door_closed = 1'b0;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        check_eq("door_open_start", 32'(bus.state), 32'd1);
        bus.door_closed = 1'b1;
        pulse_dv(0);
        cyc(1);
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        check_eq("zero_start", 32'(bus.state), 32'd1);
        bus.start = 1'b1;
        bus.stop = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        bus.stop = 1'b0;
        check_eq("startstop_state", 32'(bus.state), 32'd0);
        check_eq("startstop_clrn", 32'(bus.cnt_clrn), 32'd0);
        cyc(1);
        check_eq("startstop_clrn1", 32'(bus.cnt_clrn), 32'd1);

        // Door opens mid-second, then resume keeps the residual prescale
        pulse_dv(9);
        cyc(1);
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(4);
        check_eq("first_tick", 32'(bus.cnt_en), 32'd1);
        cyc(2);
        bus.door_closed = 1'b0;
        cyc(1);
        check_eq("pause_state", 32'(bus.state), 32'd3);
        check_eq("pause_mag", 32'(bus.mag_on), 32'd0);
        check_eq("pause_light", 32'(bus.light_on), 32'd1);
        en_seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            en_seen |= bus.cnt_en;
        end
        check_eq("pause_no_en", 32'(en_seen), 32'd0);
        bus.door_closed = 1'b1;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        check_eq("resume_state", 32'(bus.state), 32'd2);
        cyc(1);
        check_eq("resume_en1", 32'(bus.cnt_en), 32'd0);
        cyc(1);
        check_eq("resume_en2", 32'(bus.cnt_en), 32'd1);

        // Stop while cooking pauses; pause either times out or holds
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        check_eq("stop_pause", 32'(bus.state), 32'd3);
`ifdef MWTC_PAUSE_TIMEOUT_EN
        cyc(5);
        check_eq("pause_hold5", 32'(bus.state), 32'd3);
        cyc(1);
        check_eq("timeout_state", 32'(bus.state), 32'd0);
        check_eq("timeout_clrn", 32'(bus.cnt_clrn), 32'd0);
`else
        cyc(100);
        check_eq("pause_hold100", 32'(bus.state), 32'd3);
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        check_eq("pause_stop", 32'(bus.state), 32'd0);
        check_eq("pause_stop_clrn", 32'(bus.cnt_clrn), 32'd0);
`endif
        cyc(1);

        // Reset while cooking
        pulse_dv(9);
        cyc(1);
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(2);
        clr = 1'b1;
        cyc(1);
        check_eq("clr_state", 32'(bus.state), 32'd0);
        check_eq("clr_mag", 32'(bus.mag_on), 32'd0);
        check_eq("clr_clrn", 32'(bus.cnt_clrn), 32'd0);
        check_eq("clr_loadn", 32'(bus.cnt_loadn), 32'd1);
        cyc(1);
        clr = 1'b0;
        cyc(1);
        check_eq("clr_release", 32'(bus.cnt_clrn), 32'd1);

        // Random traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            bus.digits_valid = ($urandom_range(0, 19) == 0);
            if (bus.digits_valid) key_secs = $urandom_range(0, 6);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.stop  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) bus.door_closed = !bus.door_closed;
            clr = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        bus.digits_valid = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        clr = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
